// File: rtl/adder_share_arbiter.sv
// Shares one DATA_W-bit adder among NUM_REQ valid/ready requesters and returns a registered, ID-tagged sum.
// Define ADDER_SHARE_FIXED_PRIO_EN for fixed lowest-index priority; round-robin by default.
module adder_share_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 32,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [ID_W-1:0]           rsp_id_o,
  output logic [DATA_W-1:0]         rsp_sum_o,
  output logic                      rsp_carry_o
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_sum_q, rsp_sum_d;
  logic              rsp_carry_q, rsp_carry_d;

  logic [ID_W-1:0]   search_base;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_found;
  logic              can_accept;
  logic              transfer;
  logic [DATA_W:0]   sum_full;

  logic [DATA_W-1:0] op_a [NUM_REQ];
  logic [DATA_W-1:0] op_b [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign op_a[k] = req_a_i[k*DATA_W +: DATA_W];
    assign op_b[k] = req_b_i[k*DATA_W +: DATA_W];
  end

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Reset gates acceptance so no grant is visible while rst_i is high.
  assign can_accept = !rst_i && ((state_q == IDLE) || rsp_ready_i);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid_i[wrap_idx(search_base, i)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(search_base, i);
      end
    end
  end

  assign transfer = can_accept && grant_found;
  assign sum_full = {1'b0, op_a[grant_idx]} + {1'b0, op_b[grant_idx]};

  always_comb begin
    req_ready_o = '0;
    if (transfer) req_ready_o[grant_idx] = 1'b1;
  end

`ifdef ADDER_SHARE_FIXED_PRIO_EN
  assign search_base = '0;
`else
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (transfer) rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  assign search_base = rr_ptr_q;
`endif

  // A transfer in HOLD overwrites the consumed result back-to-back.
  always_comb begin
    state_d     = state_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    case (state_q)
      IDLE:    if (transfer) state_d = HOLD;
      HOLD:    if (rsp_ready_i && !transfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (transfer) begin
      rsp_id_d                 = grant_idx;
      {rsp_carry_d, rsp_sum_d} = sum_full;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  assign rsp_valid_o = (state_q == HOLD);
  assign rsp_id_o    = rsp_id_q;
  assign rsp_sum_o   = rsp_sum_q;
  assign rsp_carry_o = rsp_carry_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: randomized requesters, grant model and a decoupled response monitor.
module tb_adder_share_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [N-1:0]     req_valid_i;
  logic [N*W-1:0]   req_a_i;
  logic [N*W-1:0]   req_b_i;
  logic [N-1:0]     req_ready_o;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [1:0]       rsp_id_o;
  logic [W-1:0]     rsp_sum_o;
  logic             rsp_carry_o;

  adder_share_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_sum_o   (rsp_sum_o),
    .rsp_carry_o (rsp_carry_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] sum;
    logic         carry;
  } exp_t;

  exp_t         sb_q[$];
  bit           pend_v [N];
  logic [W-1:0] pend_a [N];
  logic [W-1:0] pend_b [N];
  int           rr_start;
  int           exp_grant;
  bit           prev_rst;
  int           vectors;
  int           miscompares;

  task automatic setReq(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    pend_v[k] = 1'b1;
    pend_a[k] = a;
    pend_b[k] = b;
  endtask

  task automatic newOperands(input int k);
    case ($urandom_range(7))
      0:       setReq(k, 32'hFFFF_FFFF, 32'h1);
      1:       setReq(k, 32'h8000_0000, 32'h8000_0000);
      default: setReq(k, $urandom, $urandom);
    endcase
  endtask

  // Winner is the first pending requester in circular order from the slot after the last winner.
  function automatic int modelWinner(input bit can);
    if (!can) return -1;
    for (int off = 0; off < N; off++) begin
      if (pend_v[(rr_start + off) % N]) return (rr_start + off) % N;
    end
    return -1;
  endfunction

  task automatic checkOutput();
    logic [N-1:0] exp_ready;
    bit can;
    can       = !rst_i && (sb_q.size() == 0 || rsp_ready_i);
    exp_grant = modelWinner(can);
    exp_ready = '0;
    if (exp_grant >= 0) exp_ready[exp_grant] = 1'b1;
    vectors++;
    if (req_ready_o !== exp_ready) begin
      miscompares++;
      $display("[TB] FAIL grant t=%0t req_ready_o=%b expected=%b", $time, req_ready_o, exp_ready);
    end
    if (rst_i && prev_rst) begin
      vectors++;
      if ({rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_carry_o} !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset_regs t=%0t valid=%b id=%0d sum=%h carry=%b expected all zero",
                 $time, rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_carry_o);
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input int valid_pct, input int ready_pct);
    exp_t e;
    longint unsigned s;
    @(negedge clk_i);
    rst_i = rst;
    for (int k = 0; k < N; k++) begin
      if (!pend_v[k] && $urandom_range(99) < valid_pct) newOperands(k);
      req_valid_i[k]     = pend_v[k];
      req_a_i[k*W +: W]  = pend_a[k];
      req_b_i[k*W +: W]  = pend_b[k];
    end
    rsp_ready_i = ($urandom_range(99) < ready_pct);
    #1 checkOutput();
    @(posedge clk_i);
    prev_rst = rst;
    if (rst) begin
      sb_q.delete();
      rr_start = 0;
    end else if (exp_grant >= 0) begin
      s       = 64'(pend_a[exp_grant]) + 64'(pend_b[exp_grant]);
      e.id    = 2'(exp_grant);
      e.sum   = s[W-1:0];
      e.carry = s[W];
      sb_q.push_back(e);
      pend_v[exp_grant] = 1'b0;
`ifdef ADDER_SHARE_FIXED_PRIO_EN
      rr_start = 0;
`else
      rr_start = (exp_grant + 1) % N;
`endif
    end
  endtask

  // Monitor: the queue head must match whatever result the DUT presents; pop on consumption.
  initial begin
    forever begin
      @(negedge clk_i);
      #3;
      vectors++;
      if (rsp_valid_o !== (sb_q.size() != 0)) begin
        miscompares++;
        $display("[TB] FAIL rsp_valid t=%0t rsp_valid_o=%b expected=%b", $time, rsp_valid_o, sb_q.size() != 0);
      end else if (rsp_valid_o) begin
        if (rsp_id_o !== sb_q[0].id || rsp_sum_o !== sb_q[0].sum || rsp_carry_o !== sb_q[0].carry) begin
          miscompares++;
          $display("[TB] FAIL rsp_data t=%0t got id=%0d sum=%h carry=%b expected id=%0d sum=%h carry=%b",
                   $time, rsp_id_o, rsp_sum_o, rsp_carry_o, sb_q[0].id, sb_q[0].sum, sb_q[0].carry);
        end
        if (rsp_ready_i) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rr_start    = 0;
    prev_rst    = 1'b1;
    rst_i       = 1'b1;
    rsp_ready_i = 1'b0;
    req_valid_i = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    for (int k = 0; k < N; k++) setReq(k, $urandom, $urandom);

    repeat (3) applyStimulus(1'b1, 100, 100);
    for (int k = 0; k < N; k++) pend_v[k] = 1'b0;

    setReq(0, 32'd5, 32'd7);
    repeat (2) applyStimulus(1'b0, 0, 100);

    setReq(1, 32'hFFFF_FFFF, 32'h1);
    setReq(2, 32'h8000_0000, 32'h8000_0000);
    repeat (3) applyStimulus(1'b0, 0, 100);

    repeat (10) applyStimulus(1'b0, 100, 100);
    repeat (6) applyStimulus(1'b0, 0, 100);

    setReq(1, $urandom, $urandom);
    applyStimulus(1'b0, 0, 100);
    setReq(2, $urandom, $urandom);
    repeat (5) applyStimulus(1'b0, 0, 0);
    repeat (2) applyStimulus(1'b0, 0, 100);

    setReq(3, $urandom, $urandom);
    repeat (2) applyStimulus(1'b0, 0, 0);
    applyStimulus(1'b1, 50, 0);
    repeat (3) applyStimulus(1'b0, 50, 100);

    repeat (600) applyStimulus($urandom_range(99) < 2, $urandom_range(100), $urandom_range(100));

    repeat (8) applyStimulus(1'b0, 0, 100);
    vectors++;
    if (sb_q.size() != 0 || rsp_valid_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL drain queue=%0d rsp_valid_o=%b expected queue=0 rsp_valid_o=0", sb_q.size(), rsp_valid_o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
